// File: rtl/atom_pkg.sv
// Shared decode constants: RV32 base opcodes, one-hot instruction formats,
// skid-buffer states and the opcode classifier used by the decode stage.
package atom_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [4:0] FMT_I    = 5'b10000;
  localparam logic [4:0] FMT_S    = 5'b01000;
  localparam logic [4:0] FMT_B    = 5'b00100;
  localparam logic [4:0] FMT_U    = 5'b00010;
  localparam logic [4:0] FMT_J    = 5'b00001;
  localparam logic [4:0] FMT_NONE = 5'b00000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  function automatic logic [4:0] fmt_of(input logic [6:0] op);
    logic [4:0] f;
    f = FMT_NONE;
    case (op)
      OP_LUI, OP_AUIPC:                               f = FMT_U;
      OP_JAL:                                         f = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM:  f = FMT_I;
      OP_STORE:                                       f = FMT_S;
      OP_BRANCH:                                      f = FMT_B;
      default:                                        f = FMT_NONE;
    endcase
    return f;
  endfunction

  // R-type carries no immediate, so it is the one legal opcode with FMT_NONE.
  function automatic logic op_legal(input logic [6:0] op);
    return (fmt_of(op) != FMT_NONE) || (op == OP_OP);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake/bus bundle of the decode stage.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_fmt;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_fmt, out_rd, out_rs1,
           out_rs2, out_opcode, out_funct3, out_funct7, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_fmt, out_rd, out_rs1,
           out_rs2, out_opcode, out_funct3, out_funct7, out_illegal
  );
endinterface

// File: rtl/decode_stage_immediate.sv
// Combinational immediate generator; format selects are one-hot, none set
// yields zero.
module immediate #(parameter int XLEN = 32) (
  input  logic [31:0]     instr_i,
  input  logic            is_type_i_i,
  input  logic            is_type_s_i,
  input  logic            is_type_b_i,
  input  logic            is_type_u_i,
  input  logic            is_type_j_i,
  output logic [XLEN-1:0] imm_o
);
  logic [31:0] imm32;

  always_comb begin
    imm32 = 32'd0;
    if (is_type_i_i)
      imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
    else if (is_type_s_i)
      imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    else if (is_type_b_i)
      imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    else if (is_type_u_i)
      imm32 = {instr_i[31:12], 12'd0};
    else if (is_type_j_i)
      imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  end

  // Wider datapaths keep the RV sign-extension of every immediate.
  assign imm_o = XLEN'($signed(imm32));
endmodule

// File: rtl/decode_stage.sv
// Decode stage: classifies the incoming instruction, builds its immediate and
// holds decoded records in a main+skid buffer so in_ready is purely registered.
module decode_stage
  import atom_pkg::*;
#(parameter int XLEN = 32) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      fmt;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            illegal;
  } rec_t;

  rec_t       rec_in, main_q, main_d, skid_q, skid_d;
  buf_state_e state_q, state_d;
  logic [4:0] fmt_in;
  logic [XLEN-1:0] imm_in;
  logic       acc;

  assign fmt_in = fmt_of(bus.in_instr[6:0]);

  immediate #(.XLEN(XLEN)) u_imm (
    .instr_i     (bus.in_instr),
    .is_type_i_i (fmt_in[4]),
    .is_type_s_i (fmt_in[3]),
    .is_type_b_i (fmt_in[2]),
    .is_type_u_i (fmt_in[1]),
    .is_type_j_i (fmt_in[0]),
    .imm_o       (imm_in)
  );

  always_comb begin
    rec_in.pc      = bus.in_pc;
    rec_in.imm     = imm_in;
    rec_in.fmt     = fmt_in;
    rec_in.rd      = bus.in_instr[11:7];
    rec_in.rs1     = bus.in_instr[19:15];
    rec_in.rs2     = bus.in_instr[24:20];
    rec_in.opcode  = bus.in_instr[6:0];
    rec_in.funct3  = bus.in_instr[14:12];
    rec_in.funct7  = bus.in_instr[31:25];
    rec_in.illegal = !op_legal(bus.in_instr[6:0]) || (bus.in_instr[1:0] != 2'b11);
  end

  assign acc = bus.in_valid && (state_q != ST_FULL);

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush drops everything; a concurrent dequeue needs no extra handling.
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (acc) begin
          main_d  = rec_in;
          state_d = ST_ONE;
        end
        ST_ONE: begin
          if (acc && bus.out_ready) begin
            main_d = rec_in;
          end else if (acc) begin
            skid_d  = rec_in;
            state_d = ST_FULL;
          end else if (bus.out_ready) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: if (bus.out_ready) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.in_ready    = (state_q != ST_FULL);
  assign bus.out_valid   = (state_q != ST_EMPTY);
  assign bus.out_pc      = main_q.pc;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_funct3  = main_q.funct3;
  assign bus.out_funct7  = main_q.funct7;
  assign bus.out_illegal = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a queue-of-records reference model plus
// directed scenarios for reset, back-to-back, backpressure, illegal and flush.
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus();
  decode_stage #(.XLEN(32)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  fmt, rd, rs1, rs2;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sx(input int raw, input int bits);
    return (raw >= (1 << (bits - 1))) ? raw - (1 << bits) : raw;
  endfunction

  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.pc = pc;  e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.op = ins[6:0]; e.f3 = ins[14:12]; e.f7 = ins[31:25];
    e.ill = 1'b0; e.fmt = 5'b00000; e.imm = 32'd0;
    case (ins[6:0])
      7'b0110111, 7'b0010111: begin e.fmt = 5'b00010; e.imm = ins & 32'hFFFFF000; end
      7'b1101111: begin
        e.fmt = 5'b00001;
        e.imm = sx(int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * 4096 +
                   int'(ins[20]) * 2048 + int'(ins[30:21]) * 2, 21);
      end
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        e.fmt = 5'b10000; e.imm = sx(int'(ins[31:20]), 12);
      end
      7'b0100011: begin
        e.fmt = 5'b01000; e.imm = sx(int'(ins[31:25]) * 32 + int'(ins[11:7]), 12);
      end
      7'b1100011: begin
        e.fmt = 5'b00100;
        e.imm = sx(int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
                   int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2, 13);
      end
      7'b0110011: ;
      default: e.ill = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) e.ill = 1'b1;
    return e;
  endfunction

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                     input logic ordy, input logic fl, input logic r);
    exp_t e;
    bit   acc;
    rst = r; flush = fl;
    bus.in_valid = v; bus.in_instr = ins; bus.in_pc = pc; bus.out_ready = ordy;
    acc = v && (q.size() < 2);
    e = ref_dec(ins, pc);
    @(posedge clk);
    if (r || fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
    if (q.size() > 0) begin
      chk("pc", bus.out_pc, q[0].pc);
      chk("imm", bus.out_imm, q[0].imm);
      chk("fmt", {27'd0, bus.out_fmt}, {27'd0, q[0].fmt});
      chk("rd", {27'd0, bus.out_rd}, {27'd0, q[0].rd});
      chk("rs1", {27'd0, bus.out_rs1}, {27'd0, q[0].rs1});
      chk("rs2", {27'd0, bus.out_rs2}, {27'd0, q[0].rs2});
      chk("opcode", {25'd0, bus.out_opcode}, {25'd0, q[0].op});
      chk("funct3", {29'd0, bus.out_funct3}, {29'd0, q[0].f3});
      chk("funct7", {25'd0, bus.out_funct7}, {25'd0, q[0].f7});
      chk("illegal", {31'd0, bus.out_illegal}, {31'd0, q[0].ill});
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"}, {31'd0, bus.out_valid}, 32'd0);
    chk({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_pc"}, bus.out_pc, 32'd0);
    chk({tag, "_imm"}, bus.out_imm, 32'd0);
    chk({tag, "_fmt"}, {27'd0, bus.out_fmt}, 32'd0);
    chk({tag, "_regs"}, {17'd0, bus.out_rd, bus.out_rs1, bus.out_rs2}, 32'd0);
    chk({tag, "_fn"}, {15'd0, bus.out_opcode, bus.out_funct3, bus.out_funct7}, 32'd0);
    chk({tag, "_ill"}, {31'd0, bus.out_illegal}, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] ins;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
            7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111, 7'b1110011, 7'b1010111};
    ins = $urandom;
    if ($urandom_range(0, 7) != 0) ins[6:0] = ops[$urandom_range(0, 11)];
    return ins;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.out_ready = 1'b0;
    @(negedge clk);
    cyc(0, 0, 0, 1, 0, 1);
    chk_zero("reset");

    cyc(1, 32'hFFF00093, 32'h100, 1, 0, 0);
    chk("addi_fmt", {27'd0, bus.out_fmt}, 32'h10);
    chk("addi_imm", bus.out_imm, 32'hFFFFFFFF);
    chk("addi_rd", {27'd0, bus.out_rd}, 32'd1);
    chk("addi_pc", bus.out_pc, 32'h100);

    cyc(1, 32'h123452B7, 32'h104, 1, 0, 0);
    chk("lui_imm", bus.out_imm, 32'h12345000);
    chk("lui_fmt", {27'd0, bus.out_fmt}, 32'h02);
    chk("lui_rd", {27'd0, bus.out_rd}, 32'd5);
    cyc(1, 32'hFE20AE23, 32'h108, 1, 0, 0);
    chk("sw_imm", bus.out_imm, 32'hFFFFFFFC);
    chk("sw_fmt", {27'd0, bus.out_fmt}, 32'h08);
    chk("sw_rs", {22'd0, bus.out_rs1, bus.out_rs2}, {22'd0, 5'd1, 5'd2});
    cyc(1, 32'hFE000CE3, 32'h10C, 1, 0, 0);
    chk("beq_imm", bus.out_imm, 32'hFFFFFFF8);
    chk("beq_fmt", {27'd0, bus.out_fmt}, 32'h04);
    cyc(0, 0, 0, 1, 0, 0);

    // backpressure: two accepts stall into the skid entry
    cyc(1, 32'hFFF00093, 32'h200, 0, 0, 0);
    cyc(1, 32'h123452B7, 32'h204, 0, 0, 0);
    chk("bp_rdy", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_pc0", bus.out_pc, 32'h200);
    cyc(1, 32'hFE20AE23, 32'h208, 0, 0, 0);
    chk("bp_hold", bus.out_pc, 32'h200);
    cyc(0, 0, 0, 1, 0, 0);
    chk("bp_pc1", bus.out_pc, 32'h204);
    cyc(0, 0, 0, 1, 0, 0);
    chk("bp_drain", {31'd0, bus.out_valid}, 32'd0);

    cyc(1, 32'h00000000, 32'h300, 1, 0, 0);
    chk("zero_ill", {31'd0, bus.out_illegal}, 32'd1);
    chk("zero_fmt", {27'd0, bus.out_fmt}, 32'd0);
    chk("zero_imm", bus.out_imm, 32'd0);
    cyc(1, 32'h002081B3, 32'h304, 1, 0, 0);
    chk("add_ill", {31'd0, bus.out_illegal}, 32'd0);
    chk("add_fmt", {27'd0, bus.out_fmt}, 32'd0);
    cyc(0, 0, 0, 1, 0, 0);

    // flush from FULL with a concurrent fetch
    cyc(1, 32'hFFF00093, 32'h400, 0, 0, 0);
    cyc(1, 32'h123452B7, 32'h404, 0, 0, 0);
    cyc(1, 32'hFE20AE23, 32'h408, 0, 1, 0);
    chk("flush_vld", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_rdy", {31'd0, bus.in_ready}, 32'd1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("flush_gone", {31'd0, bus.out_valid}, 32'd0);

    // reset from FULL
    cyc(1, 32'hFFF00093, 32'h500, 0, 0, 0);
    cyc(1, 32'h123452B7, 32'h504, 0, 0, 0);
    cyc(1, 32'hFE20AE23, 32'h508, 1, 0, 1);
    chk_zero("rst_full");

    repeat (3000) begin
      cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFFFFFC,
          $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
